// File: rtl/mac_da_lookup_sched_if.sv
// Bundle of request/response and MAC-table lookup signals shared by the
// DA lookup scheduler and its requesters / table.
interface mac_da_lookup_sched_if #(
  parameter int pPORT_NUM = 4,
  parameter int pADDR_W   = 14
);
  localparam int PW = (pPORT_NUM > 1) ? $clog2(pPORT_NUM) : 1;

  logic [pPORT_NUM-1:0]         i_req;
  logic [pPORT_NUM*pADDR_W-1:0] i_da;
  logic [pPORT_NUM-1:0]         o_ack;
  logic                         i_tbl_wr_en;
  logic [pADDR_W-1:0]           o_MAC_DA;
  logic [PW-1:0]                i_tbl_port;
  logic                         i_tbl_hit;
  logic [pPORT_NUM-1:0]         o_rsp_val;
  logic [PW-1:0]                o_rsp_port;
  logic                         o_rsp_flood;
  logic                         o_rsp_local;
  logic                         o_busy;

  // Scheduler side
  modport slave (
    input  i_req, i_da, i_tbl_wr_en, i_tbl_port, i_tbl_hit,
    output o_ack, o_MAC_DA, o_rsp_val, o_rsp_port, o_rsp_flood, o_rsp_local, o_busy
  );

  // Requester / table side
  modport master (
    output i_req, i_da, i_tbl_wr_en, i_tbl_port, i_tbl_hit,
    input  o_ack, o_MAC_DA, o_rsp_val, o_rsp_port, o_rsp_flood, o_rsp_local, o_busy
  );
endinterface

// File: rtl/mac_da_lookup_sched.sv
// Round-robin scheduler sharing the MAC table DA lookup port among the rx
// ports; waits the table read latency and returns a one-hot response.
module mac_da_lookup_sched #(
  parameter int pPORT_NUM   = 4,
  parameter int pADDR_W     = 14,
  parameter int pLOOKUP_LAT = 1
) (
  input logic                  iclk,
  input logic                  irst,
  mac_da_lookup_sched_if.slave bus
);
  localparam int PW = (pPORT_NUM > 1) ? $clog2(pPORT_NUM) : 1;
  localparam int CW = (pLOOKUP_LAT > 0) ? $clog2(pLOOKUP_LAT + 1) : 1;
  localparam logic [CW-1:0] LAT_LOAD  = CW'(pLOOKUP_LAT);
  localparam logic [PW-1:0] LAST_PORT = PW'(pPORT_NUM - 1);

  typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;

  typedef struct packed {
    logic          flood;
    logic          lcl;
    logic [PW-1:0] port;
  } rsp_t;

  state_t state, state_nxt;

  logic [PW-1:0]      rr_ptr;
  logic [CW-1:0]      cnt;
  logic [PW-1:0]      gnt_idx;
  logic [PW-1:0]      cand;
  logic               gnt_found;
  logic               take;

  logic [PW-1:0]      gnt_p0;
  logic [pADDR_W-1:0] da_p0;
  logic               tbl_hit_p1;
  logic [PW-1:0]      tbl_port_p1;

  logic [pPORT_NUM-1:0] ack;
  logic [pPORT_NUM-1:0] rsp_val;
  rsp_t                 rsp;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] g);
    return (g == LAST_PORT) ? '0 : g + PW'(1);
  endfunction

  // Miss floods; a hit pointing back at the source means the frame is local.
  function automatic rsp_t resolve(input logic hit, input logic [PW-1:0] tport,
                                   input logic [PW-1:0] src);
    rsp_t r;
    r = '0;
    if (!hit) begin
      r.flood = 1'b1;
    end else if (tport == src) begin
      r.lcl  = 1'b1;
      r.port = src;
    end else begin
      r.port = tport;
    end
    return r;
  endfunction

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 0; i < pPORT_NUM; i++) begin
      cand = PW'((int'(rr_ptr) + i) % pPORT_NUM);
      if (!gnt_found && bus.i_req[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign take = (state == IDLE) && !bus.i_tbl_wr_en && gnt_found && !irst;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = LOOKUP;
      LOOKUP:  if (cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: grant accepted, key captured and presented to the table
  always_ff @(posedge iclk) begin
    if (irst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      cnt    <= '0;
      gnt_p0 <= '0;
      da_p0  <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        gnt_p0 <= gnt_idx;
        rr_ptr <= next_ptr(gnt_idx);
        cnt    <= LAT_LOAD;
        da_p0  <= bus.i_da[int'(gnt_idx)*pADDR_W +: pADDR_W];
      end else if (state == LOOKUP && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  // Stage p1: table result sampled once the read latency has elapsed
  always_ff @(posedge iclk) begin
    if (state == LOOKUP && cnt == '0) begin
      tbl_hit_p1  <= bus.i_tbl_hit;
      tbl_port_p1 <= bus.i_tbl_port;
    end
  end

  always_comb begin
    ack = '0;
    if (take) ack[gnt_idx] = 1'b1;
  end

  always_comb begin
    rsp_val = '0;
    rsp     = '0;
    if (state == RESP) begin
      rsp_val[gnt_p0] = 1'b1;
      rsp             = resolve(tbl_hit_p1, tbl_port_p1, gnt_p0);
    end
  end

  assign bus.o_ack       = ack;
  assign bus.o_MAC_DA    = da_p0;
  assign bus.o_rsp_val   = rsp_val;
  assign bus.o_rsp_port  = rsp.port;
  assign bus.o_rsp_flood = rsp.flood;
  assign bus.o_rsp_local = rsp.lcl;
  assign bus.o_busy      = (state != IDLE);

  always_ff @(posedge iclk) begin
    if (!irst) begin
      assert ($onehot0(ack));
      assert ($onehot0(rsp_val));
      assert (!((|ack) && (|rsp_val)));
    end
  end
endmodule

// File: tb/tb_mac_da_lookup_sched.sv
// Directed bench for the DA lookup scheduler: single lookups, miss/local,
// round-robin order, pointer fairness, write stall and mid-lookup reset.
module tb_mac_da_lookup_sched;
  localparam int N  = 4;
  localparam int AW = 14;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mac_da_lookup_sched_if #(.pPORT_NUM(N), .pADDR_W(AW)) bus ();

  mac_da_lookup_sched #(.pPORT_NUM(N), .pADDR_W(AW), .pLOOKUP_LAT(1)) dut (
    .iclk(clk),
    .irst(rst),
    .bus (bus)
  );

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] ack, input logic [3:0] val,
                         input logic [1:0] port, input logic fl, input logic lc,
                         input logic bsy);
    cmp({tag, ".ack"},   32'(bus.o_ack),       32'(ack));
    cmp({tag, ".val"},   32'(bus.o_rsp_val),   32'(val));
    cmp({tag, ".port"},  32'(bus.o_rsp_port),  32'(port));
    cmp({tag, ".flood"}, 32'(bus.o_rsp_flood), 32'(fl));
    cmp({tag, ".local"}, 32'(bus.o_rsp_local), 32'(lc));
    cmp({tag, ".busy"},  32'(bus.o_busy),      32'(bsy));
  endtask

  task automatic chk_da(input string tag, input logic [AW-1:0] exp);
    cmp({tag, ".da"}, 32'(bus.o_MAC_DA), 32'(exp));
  endtask

  task automatic set_da(input int p, input logic [AW-1:0] da);
    bus.i_da[p*AW +: AW] = da;
  endtask

  // One isolated lookup from port p, starting at the next falling edge.
  task automatic lookup(input string tag, input int p, input logic [AW-1:0] da,
                        input logic hit, input logic [1:0] tp, input logic [1:0] ep,
                        input logic ef, input logic el);
    logic [3:0] oh;
    oh = 4'(1) << p;
    @(negedge clk);
    set_da(p, da);
    bus.i_req      = oh;
    bus.i_tbl_hit  = hit;
    bus.i_tbl_port = tp;
    #1 chk_out({tag, "_T0"}, oh, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.i_req = '0;
    #1 chk_out({tag, "_T1"}, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b1);
    chk_da({tag, "_T1"}, da);
    @(negedge clk);
    #1 chk_out({tag, "_T2"}, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b1);
    chk_da({tag, "_T2"}, da);
    @(negedge clk);
    #1 chk_out({tag, "_T3"}, 4'h0, oh, ep, ef, el, 1'b1);
    @(negedge clk);
    #1 chk_out({tag, "_T4"}, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         order [5];
    logic [AW-1:0] das [4];
    logic [3:0] oh;

    order = '{0, 1, 2, 3, 0};
    das   = '{14'h0101, 14'h0A22, 14'h1343, 14'h3C64};

    rst             = 1'b1;
    bus.i_req       = '0;
    bus.i_da        = '0;
    bus.i_tbl_wr_en = 1'b0;
    bus.i_tbl_port  = '0;
    bus.i_tbl_hit   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1 chk_out("reset", 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk_da("reset", 14'h0);
    rst = 1'b0;

    // Isolated lookups: remote hit, miss, local, remote hit
    lookup("single", 2, 14'h01A5, 1'b1, 2'd1, 2'd1, 1'b0, 1'b0);
    lookup("miss",   0, 14'h2B3C, 1'b0, 2'd2, 2'd0, 1'b1, 1'b0);
    lookup("local",  3, 14'h3FFF, 1'b1, 2'd3, 2'd3, 1'b0, 1'b1);
    lookup("remote", 1, 14'h0042, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0);

    // Round-robin from reset with all ports requesting continuously
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 chk_out("rr_reset", 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    for (int k = 0; k < N; k++) set_da(k, das[k]);
    bus.i_req      = 4'hF;
    bus.i_tbl_hit  = 1'b1;
    bus.i_tbl_port = 2'd2;
    for (int j = 0; j < 5; j++) begin
      oh = 4'(1) << order[j];
      #1 chk_out($sformatf("rr%0d_ack", j), oh, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      #1 chk_out($sformatf("rr%0d_w1", j), 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b1);
      chk_da($sformatf("rr%0d_w1", j), das[order[j]]);
      @(negedge clk);
      #1 chk_out($sformatf("rr%0d_w2", j), 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      #1 chk_out($sformatf("rr%0d_rsp", j), 4'h0, oh, 2'd2, 1'b0, (order[j] == 2), 1'b1);
      @(negedge clk);
    end
    // Request withdrawn before grant: no ack
    bus.i_req = '0;
    #1 chk_out("rr_drop", 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);

    // Fairness: port 0 continuous, port 2 joins after the first grant
    @(negedge clk);
    bus.i_req = 4'b0001;
    #1 chk_out("fair_g0", 4'b0001, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.i_req = 4'b0101;
    #1 chk_out("fair_w1", 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #1 chk_out("fair_w2", 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #1 chk_out("fair_rsp0", 4'h0, 4'b0001, 2'd2, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #1 chk_out("fair_g2", 4'b0100, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.i_req = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    #1 chk_out("fair_rsp2", 4'h0, 4'b0100, 2'd2, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    #1 chk_out("fair_g0b", 4'b0001, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.i_req = '0;
    @(negedge clk);
    @(negedge clk);
    #1 chk_out("fair_rsp0b", 4'h0, 4'b0001, 2'd2, 1'b0, 1'b0, 1'b1);

    // Table write holds off the grant
    @(negedge clk);
    bus.i_tbl_wr_en = 1'b1;
    bus.i_req       = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      #1 chk_out($sformatf("wr_stall%0d", c), 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
    end
    bus.i_tbl_wr_en = 1'b0;
    #1 chk_out("wr_release", 4'b0010, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.i_req = '0;
    @(negedge clk);
    @(negedge clk);
    #1 chk_out("wr_rsp", 4'h0, 4'b0010, 2'd2, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of a port 1 lookup
    @(negedge clk);
    set_da(1, 14'h0777);
    bus.i_req = 4'b0010;
    #1 chk_out("rst_T0", 4'b0010, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.i_req = '0;
    #1 chk_da("rst_T1", 14'h0777);
    @(negedge clk);
    rst = 1'b1;
    #1 chk_out("rst_T2", 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1 chk_out("rst_T3", 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk_da("rst_T3", 14'h0);
    @(negedge clk);
    #1 chk_out("rst_T4", 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    // Pointer back at 0: port 1 wins over port 3
    @(negedge clk);
    bus.i_req = 4'b1010;
    #1 chk_out("rst_ptr", 4'b0010, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.i_req = 4'b1000;
    #1 chk_da("rst_ptr_w1", 14'h0777);
    @(negedge clk);
    @(negedge clk);
    #1 chk_out("rst_ptr_rsp", 4'h0, 4'b0010, 2'd2, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #1 chk_out("rst_ptr_g3", 4'b1000, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.i_req = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mac_da_lookup_sched.md
Name: mac_da_lookup_sched

Overview:
- Shares the single destination-address lookup port of the MAC table among the pPORT_NUM receive ports of the switch.
- Each port's rx path posts a 14-bit DA key. The block grants requests round-robin, drives the table's DA input, and waits the table's fixed read latency.
- It returns a one-hot response carrying either the destination port number or a flood/local indication.
- Table writes from SA learning take priority; new lookups are held off while a write is pending.

Parameters:
pPORT_NUM, 4, number of switch ports / requesters
pADDR_W, 14, width of MAC table key (DA hash/address)
pLOOKUP_LAT, 1, cycles from table DA input change to valid table result (>=1)

Ports:
iclk  in  1  system clock, all logic on rising edge
irst  in  1  synchronous active-high reset
i_req  in  pPORT_NUM  per-port lookup request, level, held until o_ack
i_da  in  pPORT_NUM*pADDR_W  per-port DA key, port k at bits [k*pADDR_W +: pADDR_W]
o_ack  out  pPORT_NUM  one-hot, 1-cycle pulse: request accepted, key captured
i_tbl_wr_en  in  1  MAC table write in progress (learning path)
o_MAC_DA  out  pADDR_W  key driven to MAC table lookup input (registered)
i_tbl_port  in  $clog2(pPORT_NUM)  port number returned by table
i_tbl_hit  in  1  table entry valid for o_MAC_DA
o_rsp_val  out  pPORT_NUM  one-hot, 1-cycle pulse to requesting port
o_rsp_port  out  $clog2(pPORT_NUM)  destination port (valid when o_rsp_val!=0)
o_rsp_flood  out  1  DA unknown: forward to all ports except source
o_rsp_local  out  1  DA resolves to source port: drop frame
o_busy  out  1  lookup in flight (state != IDLE)

Behaviour:
- Reset: all outputs 0, state IDLE, RR pointer 0, latency counter 0. Any in-flight lookup is discarded and no o_rsp_val is issued for it.
- FSM states: IDLE -> LOOKUP -> RESP -> IDLE.
- IDLE:
  - If i_tbl_wr_en=1 or i_req=0: stay; no ack.
  - Otherwise grant g = first k with i_req[k]=1, searching from RR pointer upward mod pPORT_NUM.
  - In that cycle (T): o_ack[g]=1. At the edge ending T: o_MAC_DA<=i_da[g], grant index stored, pointer<=(g+1) mod pPORT_NUM, counter<=pLOOKUP_LAT, state<=LOOKUP.
- LOOKUP: lasts pLOOKUP_LAT+1 cycles (T+1 .. T+1+pLOOKUP_LAT), counter decrements each cycle. o_MAC_DA stays stable throughout. At the end of the cycle with counter==0, sample i_tbl_hit/i_tbl_port and go to RESP.
- RESP (cycle T+2+pLOOKUP_LAT):
  - o_rsp_val[g]=1 for exactly 1 cycle.
  - Miss (hit=0): o_rsp_flood=1, o_rsp_port=0, o_rsp_local=0.
  - Hit with port==g: o_rsp_local=1, o_rsp_port=g, o_rsp_flood=0.
  - Hit otherwise: o_rsp_port=i_tbl_port, flood=local=0.
  - Next state IDLE. Response fields return to 0 in the following cycle.
- Throughput: one lookup per pLOOKUP_LAT+3 cycles. With default, ack-to-ack is 4 cycles.
- i_tbl_wr_en is checked only in IDLE. A write arriving during LOOKUP does not abort the lookup; table read/write ordering is the table's responsibility.
- Requester holds i_req and i_da stable until o_ack. If i_req is still high in the cycle after o_ack, that is a new request.
- Requests dropped before ack are legal; no ack is issued for them.
- Simultaneous requests: only one ack per grant cycle; the others wait. Fairness: any continuously requesting port is granted within pPORT_NUM grants.
- o_ack and o_rsp_val are never both nonzero in the same cycle. At most one bit of each is set.

Test Plan:
- Single request: after reset, port 2 req, DA=0x1A5; table hit, port 1 -> o_ack=0100 at T, o_MAC_DA=0x1A5 from T+1, o_rsp_val=0100 at T+3, o_rsp_port=1, flood=local=0.
- Miss and local: port 0 DA with hit=0 -> o_rsp_flood=1 at T+3. Port 3 DA mapping to port 3 -> o_rsp_local=1, o_rsp_port=3.
- Round-robin: all four req held continuously from reset -> ack order 0,1,2,3,0, spaced 4 cycles apart; each rsp_val matches its ack.
- Fairness with pointer: port 0 requests continuously, port 2 asserts after first grant -> next grant is port 2, then port 0.
- Write stall: i_tbl_wr_en=1 for 5 cycles while port 1 requests -> no ack during those cycles; ack in the first cycle wr_en=0.
- Reset mid-lookup: irst pulsed at T+2 of a port 1 lookup -> no o_rsp_val. Outputs read 0 after the reset edge. Next request from port 1 is granted first (pointer 0, port 0 idle).
